// File: rtl/dk_audio_sink.sv
// dk_audio_sink: consumer end of the discrete-sound sample interface.
// Generates the audio_clk_en sample strobe, captures each signed 16-bit
// sample one cycle after the strobe, and averages OVERSAMPLE captures
// (floor).
// Converts the average to offset-binary and queues it in an output FIFO.
// Optional build macro DK_AUDIO_SINK_DC_BLOCK_EN inserts a DC-blocking
// high-pass stage (one extra cycle) between the average and the conversion.
//
// Output handshake: out_valid means the FIFO is not empty and out_data is
// the head word. A word is consumed on a rising clk edge where
// out_valid && out_ready. out_data holds while out_valid=1 and out_ready=0.
// out_valid never depends combinationally on out_ready.
module dk_audio_sink #(
    parameter int CLOCK_RATE  = 192000,
    parameter int SAMPLE_RATE = 96000,
    parameter int OVERSAMPLE  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               I_RSTn,
    output logic               audio_clk_en,
    input  logic signed [15:0] in,
    output logic        [15:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow
);

    localparam int DIV = CLOCK_RATE / SAMPLE_RATE;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SH  = $clog2(OVERSAMPLE);
    localparam int AW  = 16 + SH;
    localparam int CW  = (SH > 0) ? SH : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    // ---------------- strobe generation ----------------
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_next;

    assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

    // Divider counter; the strobe is registered so it is 0 in reset even when DIV==1.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            div_cnt      <= '0;
            audio_clk_en <= 1'b0;
        end else begin
            div_cnt      <= div_next;
            audio_clk_en <= (div_next == DIV_LAST);
        end
    end

    // ---------------- capture and accumulation ----------------
    logic                 cap_phase;
    logic        [CW-1:0] smp_cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] in_ext;
    logic signed [AW-1:0] sum;
    logic signed [15:0]   avg;
    logic signed [15:0]   avg_q;
    logic                 avg_vld;

    assign in_ext = AW'(in);
    assign sum    = acc + in_ext;
    assign avg    = 16'(sum >>> SH);

    // Capture phase marks the cycle after a strobe, when the producer's new sample has settled.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            cap_phase <= 1'b0;
        end else begin
            cap_phase <= audio_clk_en;
        end
    end

    // Accumulate captures; the OVERSAMPLE-th one forms the floor average and clears the sum.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            acc     <= '0;
            smp_cnt <= '0;
            avg_q   <= '0;
            avg_vld <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (cap_phase) begin
                if (smp_cnt == CNT_LAST) begin
                    avg_q   <= avg;
                    avg_vld <= 1'b1;
                    acc     <= '0;
                    smp_cnt <= '0;
                end else begin
                    acc     <= sum;
                    smp_cnt <= smp_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- optional DC block and conversion ----------------
    logic [15:0] push_word;
    logic        push_vld;

`ifdef DK_AUDIO_SINK_DC_BLOCK_EN
    localparam logic signed [17:0] SAT_HI = 18'sd32767;
    localparam logic signed [17:0] SAT_LO = -18'sd32768;

    logic signed [15:0] x_prev;
    logic signed [15:0] y_prev;
    logic signed [17:0] dc_sum;
    logic signed [15:0] y_sat;

    assign dc_sum = 18'(avg_q) - 18'(x_prev) + 18'(y_prev) - 18'(y_prev >>> 8);

    // Saturate the 18-bit filter result back to the 16-bit sample range.
    always_comb begin
        y_sat = dc_sum[15:0];
        if (dc_sum > SAT_HI) begin
            y_sat = 16'sh7FFF;
        end else if (dc_sum < SAT_LO) begin
            y_sat = 16'sh8000;
        end
    end

    // Filter state advances once per average; its output is the word pushed next cycle.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            x_prev    <= '0;
            y_prev    <= '0;
            push_word <= '0;
            push_vld  <= 1'b0;
        end else begin
            push_vld <= avg_vld;
            if (avg_vld) begin
                x_prev    <= avg_q;
                y_prev    <= y_sat;
                push_word <= y_sat ^ 16'h8000;
            end
        end
    end
`else
    assign push_word = avg_q ^ 16'h8000;
    assign push_vld  = avg_vld;
`endif

    // ---------------- output FIFO ----------------
    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic [15:0]   last_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          do_push;

    assign wr_idx    = wr_ptr[PW-1:0];
    assign rd_idx    = rd_ptr[PW-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push   = push_vld && (!full || pop);
    assign out_data  = empty ? last_q : mem[rd_idx];

    // Storage array; contents are only visible through valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_word;
        end
    end

    // Pointers, last-popped word (shown while empty) and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_idx];
            end
            if (push_vld && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
